pipelined_prefix_adder: RTL and testbench
=========================================

Name: pipelined_prefix_adder

Overview:
- Parametrised, pipelined parallel-prefix (Sklansky) adder/subtractor with a valid/ready handshake on input and output.
- Carries a sideband tag and produces carry, overflow and zero flags.
- Next-generation replacement for the fixed-width combinational prefix adder in the datapath library; intended for ALU and address-generation pipelines at high clock rates.

Parameters:
- WIDTH, 16, operand/result width in bits; 2..64.
- STAGES, 2, number of register banks (latency in cycles); 1..ceil(log2(WIDTH))+1.
- TAG_W, 4, sideband tag width; 1..16.

Ports:
- clock  input  1  sole clock; all state rising-edge.
- reset  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block can accept a beat this cycle.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- in_cin  input  1  carry/borrow-in; used only by ADC/SBB.
- in_op  input  2  00 ADD, 01 SUB, 10 ADC, 11 SBB.
- in_tag  input  TAG_W  opaque sideband, returned with the result.
- out_valid  output  1  result beat valid.
- out_ready  input  1  consumer accepts the result.
- out_sum  output  WIDTH  result.
- out_cout  output  1  carry-out of bit WIDTH-1 (for SUB/SBB, 1 = no borrow).
- out_ovf  output  1  signed two's-complement overflow.
- out_zero  output  1  out_sum == 0.
- out_tag  output  TAG_W  tag of this result.

Behaviour:
- Operand preparation:
  - b' = in_b for ADD/ADC, ~in_b for SUB/SBB.
  - c0 = 0 for ADD, 1 for SUB, in_cin for ADC, ~in_cin for SBB.
- Prefix network:
  - p_i = a_i^b'_i, g_i = a_i&b'_i; carry-in folded as generate at position -1.
  - L = ceil(log2(WIDTH)) Sklansky levels; combine (G,P) = (g_hi | p_hi&g_lo, p_hi&p_lo).
  - sum_i = p_i ^ c_i; cout = c_WIDTH; ovf = c_WIDTH ^ c_(WIDTH-1).
  - zero is computed from the final sum in the last stage.
- Pipelining:
  - STAGES register banks. Bank k (1..STAGES-1) sits after prefix level floor(k*(L+1)/STAGES); bank STAGES is the output register.
  - Each bank holds a valid bit, the in-flight (G,P)/p vectors and the tag.
  - STAGES=1: fully combinational to a single output register.
- Handshake and flow:
  - Input transfer on in_valid&in_ready; output transfer on out_valid&out_ready.
  - Bank k loads when it is empty or bank k+1 loads (last bank: when out_ready). Bubbles collapse.
  - in_ready = bank 1 loads this cycle; purely combinational from out_ready and the valid bits, never from in_valid.
  - Latency is exactly STAGES cycles from input transfer to out_valid when unstalled. Throughput is 1 beat/cycle with out_ready held high.
  - While out_valid&!out_ready, all out_* are held stable. No beat is dropped, duplicated or reordered.
  - Capacity is STAGES beats. When full and out_ready=0, in_ready=0.
  - In the same cycle, a full pipe with out_ready=1 accepts a new beat (in_ready=1).
  - Registers of invalid banks are don't-care for data but must not alter flags of valid beats.
- Reset (reset=0, asynchronous):
  - All valid bits clear immediately; out_valid=0.
  - out_sum=0, out_cout=0, out_ovf=0, out_zero=0, out_tag=0.
  - in_ready=1 from the first clock after release.
  - Reset mid-operation discards all in-flight beats; no partial result emerges after release.
- Arithmetic:
  - Modulo 2^WIDTH.
  - Flags are identical to the ripple-carry reference sum a + b' + c0 at width WIDTH+1.

Test Plan:
- WIDTH=16, STAGES=2, ADD 0xFFFF+0x0001, tag 3 -> after 2 cycles out_sum=0x0000, cout=1, ovf=0, zero=1, tag=3.
- SUB 0x8000-0x0001 -> out_sum=0x7FFF, cout=1, ovf=1, zero=0; SBB 0x0000-0x0000 cin=1 -> 0xFFFF, cout=0, ovf=0.
- ADC 0x7FFF+0x0000 cin=1 -> 0x8000, ovf=1, cout=0. Then 100 back-to-back random beats with out_ready=1 -> one result per cycle, in order, tags 0..15 cycling.
- Hold out_ready=0 for 5 cycles while streaming -> exactly STAGES beats accepted, in_ready=0 afterwards, out_* stable. Release -> all beats drain in order.
- Assert reset=0 asynchronously with 2 beats in flight -> out_valid falls without a clock edge. After release, no stale results appear and in_ready=1.
- Exhaustive, WIDTH=7, STAGES in {1,2,4}: all a, b, op, cin -> every result and flag matches the scoreboard model a + b' + c0.

Source files
------------

// File: rtl/pipelined_prefix_adder.sv
// rtl/pipelined_prefix_adder.sv - pipelined Sklansky adder/subtractor with valid/ready flow and carry/ovf/zero flags
module pipelined_prefix_adder #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 2,
    parameter int TAG_W  = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic [1:0]       in_op,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             out_zero,
    output logic [TAG_W-1:0] out_tag
);

    localparam int L  = $clog2(WIDTH);
    localparam int NB = (STAGES > 1) ? STAGES - 1 : 1;

    // Number of prefix levels already applied to the data held in bank k.
    function automatic int bank_level(input int k);
        if (k <= 0)
            return 0;
        if (k >= STAGES)
            return L;
        return (k * (L + 1)) / STAGES;
    endfunction

    logic [STAGES-1:0] v_q;
    logic [STAGES-1:0] load;
    logic [STAGES-1:0] vin;

    logic [WIDTH-1:0] g_q   [NB];
    logic [WIDTH-1:0] pg_q  [NB];
    logic [WIDTH-1:0] p_q   [NB];
    logic             c0_q  [NB];
    logic [TAG_W-1:0] tag_q [NB];

    logic [WIDTH-1:0] g_d   [STAGES];
    logic [WIDTH-1:0] pg_d  [STAGES];
    logic [WIDTH-1:0] p_d   [STAGES];
    logic             c0_d  [STAGES];
    logic [TAG_W-1:0] tag_d [STAGES];

    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;
    logic             zero_q;
    logic [TAG_W-1:0] otag_q;

    logic [WIDTH-1:0] b_x;
    logic [WIDTH-1:0] p0;
    logic [WIDTH-1:0] g0;
    logic [WIDTH-1:0] pg0;
    logic             c0;

    logic [WIDTH-1:0] cg;
    logic [WIDTH-1:0] cpg;

    logic [WIDTH-1:0] fg;
    logic [WIDTH-1:0] carry;
    logic [WIDTH-1:0] fsum;
    logic             fcout;
    logic             fovf;

    // The carry-in is merged into bit 0's generate so L levels cover the whole word.
    assign b_x = in_op[0] ? ~in_b : in_b;
    assign c0  = in_op[1] ? (in_cin ^ in_op[0]) : in_op[0];
    assign p0  = in_a ^ b_x;
    assign g0  = (in_a & b_x) | {{(WIDTH-1){1'b0}}, p0[0] & c0};
    assign pg0 = {p0[WIDTH-1:1], 1'b0};

    always_comb begin
        load = '0;
        load[STAGES-1] = !v_q[STAGES-1] || out_ready;
        for (int b = STAGES - 2; b >= 0; b--)
            load[b] = !v_q[b] || load[b+1];
    end

    assign in_ready = load[0];

    always_comb begin
        cg  = '0;
        cpg = '0;
        vin = '0;
        for (int s = 0; s < STAGES; s++) begin
            g_d[s]   = '0;
            pg_d[s]  = '0;
            p_d[s]   = '0;
            c0_d[s]  = 1'b0;
            tag_d[s] = '0;
        end
        for (int s = 0; s < STAGES; s++) begin
            if (s == 0) begin
                cg       = g0;
                cpg      = pg0;
                p_d[s]   = p0;
                c0_d[s]  = c0;
                tag_d[s] = in_tag;
                vin[s]   = in_valid;
            end else begin
                cg       = g_q[s-1];
                cpg      = pg_q[s-1];
                p_d[s]   = p_q[s-1];
                c0_d[s]  = c0_q[s-1];
                tag_d[s] = tag_q[s-1];
                vin[s]   = v_q[s-1];
            end
            for (int l = 1; l <= L; l++) begin
                if (l > bank_level(s) && l <= bank_level(s + 1)) begin
                    // Upper half of each 2^l block absorbs the top of its lower half.
                    for (int i = 0; i < WIDTH; i++) begin
                        if (((i >> (l - 1)) & 1) == 1) begin
                            cg[i]  = cg[i] | (cpg[i] & cg[((i >> (l - 1)) << (l - 1)) - 1]);
                            cpg[i] = cpg[i] & cpg[((i >> (l - 1)) << (l - 1)) - 1];
                        end
                    end
                end
            end
            g_d[s]  = cg;
            pg_d[s] = cpg;
        end
    end

    assign fg    = g_d[STAGES-1];
    assign carry = {fg[WIDTH-2:0], c0_d[STAGES-1]};
    assign fsum  = p_d[STAGES-1] ^ carry;
    assign fcout = fg[WIDTH-1];
    assign fovf  = fg[WIDTH-1] ^ carry[WIDTH-1];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            v_q <= '0;
            for (int b = 0; b < NB; b++) begin
                g_q[b]   <= '0;
                pg_q[b]  <= '0;
                p_q[b]   <= '0;
                c0_q[b]  <= 1'b0;
                tag_q[b] <= '0;
            end
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
            otag_q <= '0;
        end else begin
            for (int b = 0; b < STAGES - 1; b++) begin
                if (load[b]) begin
                    v_q[b]   <= vin[b];
                    g_q[b]   <= g_d[b];
                    pg_q[b]  <= pg_d[b];
                    p_q[b]   <= p_d[b];
                    c0_q[b]  <= c0_d[b];
                    tag_q[b] <= tag_d[b];
                end
            end
            if (load[STAGES-1]) begin
                v_q[STAGES-1] <= vin[STAGES-1];
                sum_q         <= fsum;
                cout_q        <= fcout;
                ovf_q         <= fovf;
                zero_q        <= (fsum == '0);
                otag_q        <= tag_d[STAGES-1];
            end
        end
    end

    assign out_valid = v_q[STAGES-1];
    assign out_sum   = sum_q;
    assign out_cout  = cout_q;
    assign out_ovf   = ovf_q;
    assign out_zero  = zero_q;
    assign out_tag   = otag_q;

endmodule

// File: tb/tb_pipelined_prefix_adder.sv
// tb/tb_pipelined_prefix_adder.sv - directed, streaming, stall, reset and exhaustive 7-bit checks
module tb_pipelined_prefix_adder;

    localparam int MS = 2;
    localparam int NX = 18;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic        in_cin;
    logic [1:0]  in_op;
    logic [3:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_sum;
    logic        out_cout;
    logic        out_ovf;
    logic        out_zero;
    logic [3:0]  out_tag;

    int total = 0;
    int bad   = 0;
    int rx    = 0;
    logic [22:0] sb[$];

    always #5 clock = ~clock;

    pipelined_prefix_adder #(.WIDTH(16), .STAGES(MS), .TAG_W(4)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_op(in_op), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_cout(out_cout), .out_ovf(out_ovf), .out_zero(out_zero),
        .out_tag(out_tag)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Returns {zero, ovf, cout, sum[15:0]} of a + b' + c0 at width w.
    function automatic logic [18:0] model(input int w, input logic [15:0] a, input logic [15:0] b,
                                          input logic [1:0] op, input logic cin);
        logic [16:0] mask;
        logic [16:0] bx;
        logic [16:0] r;
        logic [15:0] s;
        logic        c;
        mask = (17'd1 << w) - 17'd1;
        bx   = op[0] ? (~{1'b0, b} & mask) : {1'b0, b};
        case (op)
            2'd0:    c = 1'b0;
            2'd1:    c = 1'b1;
            2'd2:    c = cin;
            default: c = !cin;
        endcase
        r = {1'b0, a} + bx + {16'd0, c};
        s = r[15:0] & mask[15:0];
        return {(s == 16'd0), (a[w-1] == bx[w-1]) && (s[w-1] != a[w-1]), r[w], s};
    endfunction

    always @(negedge clock) begin
        if (!reset) begin
            sb.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL stray_beat: got tag 0x%0h sum 0x%0h expected no beat", out_tag, out_sum);
                end else begin
                    check("sb_result", {out_tag, out_zero, out_ovf, out_cout, out_sum}, sb.pop_front());
                    rx++;
                end
            end
            if (in_valid && in_ready)
                sb.push_back({in_tag, model(16, in_a, in_b, in_op, in_cin)});
        end
    end

    // Exhaustive 7-bit array: 3 depths x 6 op/cin combinations, tag carries {a,b}.
    function automatic logic [2:0] combo(input int k);
        case (k)
            0:       return 3'b000;
            1:       return 3'b010;
            2:       return 3'b100;
            3:       return 3'b101;
            4:       return 3'b110;
            default: return 3'b111;
        endcase
    endfunction

    logic        ex_valid = 1'b0;
    logic [6:0]  ex_a = '0;
    logic [6:0]  ex_b = '0;
    logic        ex_ir   [NX];
    logic        ex_ov   [NX];
    logic [6:0]  ex_sum  [NX];
    logic        ex_cout [NX];
    logic        ex_ovf  [NX];
    logic        ex_zero [NX];
    logic [13:0] ex_tag  [NX];
    int          ex_cnt  [NX];

    for (genvar c = 0; c < 3; c++) begin : g_cfg
        for (genvar k = 0; k < 6; k++) begin : g_op
            localparam int         N  = c * 6 + k;
            localparam logic [2:0] OC = combo(k);
            pipelined_prefix_adder #(.WIDTH(7), .STAGES(c == 0 ? 1 : (c == 1 ? 2 : 4)), .TAG_W(14)) u_ex (
                .clock(clock), .reset(reset),
                .in_valid(ex_valid), .in_ready(ex_ir[N]),
                .in_a(ex_a), .in_b(ex_b), .in_cin(OC[0]), .in_op(OC[2:1]), .in_tag({ex_a, ex_b}),
                .out_valid(ex_ov[N]), .out_ready(1'b1),
                .out_sum(ex_sum[N]), .out_cout(ex_cout[N]), .out_ovf(ex_ovf[N]), .out_zero(ex_zero[N]),
                .out_tag(ex_tag[N])
            );
        end
    end

    initial for (int n = 0; n < NX; n++) ex_cnt[n] = 0;

    always @(negedge clock) begin
        for (int n = 0; n < NX; n++) begin
            logic [13:0] v;
            logic [2:0]  oc;
            if (ex_valid)
                check("ex_ready", ex_ir[n], 1);
            if (ex_ov[n]) begin
                v  = ex_cnt[n][13:0];
                oc = combo(n % 6);
                check("ex_result", {ex_tag[n], ex_zero[n], ex_ovf[n], ex_cout[n], 9'd0, ex_sum[n]},
                      {v, model(7, {9'd0, v[13:7]}, {9'd0, v[6:0]}, oc[2:1], oc[0])});
                ex_cnt[n]++;
            end
        end
    end

    typedef struct {
        logic [1:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [3:0]  tag;
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
    } vec_t;

    vec_t tbl[11];

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic rand_beat(input logic [3:0] t);
        in_a   = 16'($urandom);
        in_b   = 16'($urandom);
        in_op  = 2'($urandom_range(0, 3));
        in_cin = 1'($urandom_range(0, 1));
        in_tag = t;
    endtask

    initial begin
        logic [15:0] h_sum;
        logic [3:0]  h_tag;
        logic [2:0]  h_flg;
        logic        have;
        int          acc;
        int          tg;
        int          base;

        tbl[0]  = '{2'd0, 16'hFFFF, 16'h0001, 1'b0, 4'd3,  16'h0000, 1'b1, 1'b0, 1'b1};
        tbl[1]  = '{2'd1, 16'h8000, 16'h0001, 1'b0, 4'd5,  16'h7FFF, 1'b1, 1'b1, 1'b0};
        tbl[2]  = '{2'd3, 16'h0000, 16'h0000, 1'b1, 4'd6,  16'hFFFF, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{2'd2, 16'h7FFF, 16'h0000, 1'b1, 4'd9,  16'h8000, 1'b0, 1'b1, 1'b0};
        tbl[4]  = '{2'd0, 16'h1234, 16'h4321, 1'b0, 4'd1,  16'h5555, 1'b0, 1'b0, 1'b0};
        tbl[5]  = '{2'd1, 16'h0005, 16'h0005, 1'b0, 4'd10, 16'h0000, 1'b1, 1'b0, 1'b1};
        tbl[6]  = '{2'd2, 16'hFFFF, 16'hFFFF, 1'b1, 4'd15, 16'hFFFF, 1'b1, 1'b0, 1'b0};
        tbl[7]  = '{2'd3, 16'h0003, 16'h0005, 1'b0, 4'd2,  16'hFFFE, 1'b0, 1'b0, 1'b0};
        tbl[8]  = '{2'd0, 16'h0001, 16'h0001, 1'b1, 4'd4,  16'h0002, 1'b0, 1'b0, 1'b0};
        tbl[9]  = '{2'd1, 16'h0000, 16'h0001, 1'b1, 4'd7,  16'hFFFF, 1'b0, 1'b0, 1'b0};
        tbl[10] = '{2'd3, 16'h8000, 16'h0000, 1'b1, 4'd8,  16'h7FFF, 1'b1, 1'b1, 1'b0};

        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_a = '0; in_b = '0; in_cin = 1'b0; in_op = '0; in_tag = '0;
        #3;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_bits", {out_sum, out_cout, out_ovf, out_zero, out_tag}, 0);
        repeat (2) @(negedge clock);
        check("rst_hold_valid", out_valid, 0);
        step();
        reset = 1'b1;
        @(negedge clock);
        check("post_rst_ready", in_ready, 1);

        foreach (tbl[i]) begin
            step();
            in_valid = 1'b1;
            in_a = tbl[i].a; in_b = tbl[i].b; in_op = tbl[i].op; in_cin = tbl[i].cin; in_tag = tbl[i].tag;
            @(negedge clock);
            check("vec_in_ready", in_ready, 1);
            step();
            in_valid = 1'b0;
            @(negedge clock);
            check("vec_latency_early", out_valid, 0);
            @(negedge clock);
            check("vec_out_valid", out_valid, 1);
            check("vec_sum", out_sum, tbl[i].sum);
            check("vec_flags", {out_cout, out_ovf, out_zero}, {tbl[i].cout, tbl[i].ovf, tbl[i].zero});
            check("vec_tag", out_tag, tbl[i].tag);
        end

        // Back-to-back stream with the consumer always ready.
        step();
        base = rx;
        for (int i = 0; i < 100; i++) begin
            in_valid = 1'b1;
            rand_beat(4'(i % 16));
            @(negedge clock);
            check("stream_ready", in_ready, 1);
            step();
        end
        in_valid = 1'b0;
        for (int i = 0; i < 10 && rx - base < 100; i++) step();
        check("stream_count", rx - base, 100);

        // Consumer stall: pipe fills to capacity and outputs hold.
        out_ready = 1'b0;
        acc = 0; tg = 0; have = 1'b0;
        h_sum = '0; h_tag = '0; h_flg = '0;
        in_valid = 1'b1;
        rand_beat(4'(tg));
        for (int c = 0; c < 5; c++) begin
            @(negedge clock);
            if (in_ready) acc++;
            if (out_valid) begin
                if (have) begin
                    check("stall_stable", {out_sum, out_tag, out_cout, out_ovf, out_zero},
                          {h_sum, h_tag, h_flg});
                end else begin
                    h_sum = out_sum; h_tag = out_tag; h_flg = {out_cout, out_ovf, out_zero};
                    have = 1'b1;
                end
            end
            step();
            if (in_ready) begin
                tg++;
                rand_beat(4'(tg));
            end
        end
        check("stall_accepted", acc, MS);
        @(negedge clock);
        check("stall_ready_low", in_ready, 0);
        check("stall_out_valid", out_valid, 1);
        step();
        out_ready = 1'b1;
        @(negedge clock);
        check("full_accepts", in_ready, 1);
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 10 && sb.size() != 0; i++) step();
        check("stall_drained", sb.size(), 0);

        // Asynchronous reset with two beats in flight.
        out_ready = 1'b0;
        in_valid = 1'b1;
        rand_beat(4'd11);
        step();
        rand_beat(4'd12);
        step();
        in_valid = 1'b0;
        @(negedge clock);
        check("pre_rst_valid", out_valid, 1);
        #2;
        reset = 1'b0;
        #1;
        check("async_rst_valid", out_valid, 0);
        check("async_rst_bits", {out_sum, out_cout, out_ovf, out_zero, out_tag}, 0);
        step();
        step();
        reset = 1'b1;
        out_ready = 1'b1;
        @(negedge clock);
        check("rst_release_ready", in_ready, 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check("no_stale_beat", out_valid, 0);
        end

        // Exhaustive 7-bit sweep across all depths and op/cin combinations.
        step();
        ex_valid = 1'b1;
        for (int v = 0; v < 16384; v++) begin
            logic [13:0] vv;
            vv = v[13:0];
            ex_a = vv[13:7];
            ex_b = vv[6:0];
            step();
        end
        ex_valid = 1'b0;
        repeat (8) step();
        for (int n = 0; n < NX; n++)
            check("ex_count", ex_cnt[n], 16384);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
